rmii_tx_serializer: RTL and testbench

Parametrised successor to the dibit RMII transmit path. Accepts a byte stream (valid/ready/last) in the single RMII reference clock domain. Serialises each byte LSB-first onto a DATA_W-wide PHY bus (2 = RMII, 4 = MII-style nibble). Adds 10 Mb/s symbol repetition, back-to-back byte pipelining, underrun detection and enforced inter-packet gap. Sits between the frame builder (preamble/CRC already inserted upstream) and the PHY pins.

---
 rtl/rmii_pkg.sv | 8 +
 rtl/rmii_tx_serializer_if.sv | 9 +
 rtl/rmii_slot_timer.sv | 24 ++
 rtl/rmii_tx_serializer.sv | 66 ++++++
 tb/tb_rmii_tx_serializer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rmii_pkg.sv
// rmii_pkg: shared state encoding and default parameters for the RMII transmit path
package rmii_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_IPG} state_t;
  localparam int DATA_W_RMII = 2;
  localparam int DATA_W_MII = 4;
  localparam int IPG_BYTES_STD = 12;
  localparam int SLOW_DIV_RMII = 10;
endpackage

// File: rtl/rmii_tx_serializer_if.sv
// rmii_tx_serializer_if: byte stream handshake from the frame builder into the serializer
interface rmii_tx_serializer_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  modport master(output in_data, in_valid, in_last, input in_ready);
  modport slave(input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/rmii_slot_timer.sv
// rmii_slot_timer: symbol slot counter and inter-packet gap counter with 10/100 speed select
module rmii_slot_timer #(
  parameter int SLOW_DIV = 10,
  parameter int IPG_FAST = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic spd,
  input  logic run_slot,
  input  logic run_ipg,
  output logic slot_end,
  output logic ipg_done
);
  localparam int SW = $clog2(SLOW_DIV + 1);
  localparam int IW = $clog2(IPG_FAST * SLOW_DIV + 1);
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] ipg_cnt;
  assign slot_end = !spd || slot_cnt == SW'(SLOW_DIV - 1);
  assign ipg_done = run_ipg && ipg_cnt == (spd ? IW'(IPG_FAST * SLOW_DIV - 1) : IW'(IPG_FAST - 1));
  always_ff @(posedge clk) begin
    slot_cnt <= (rst || !run_slot || slot_end) ? '0 : slot_cnt + 1'b1;
    ipg_cnt <= (rst || !run_ipg) ? '0 : ipg_cnt + 1'b1;
  end
endmodule

// File: rtl/rmii_tx_serializer.sv
// rmii_tx_serializer: byte stream to LSB-first DATA_W symbol serializer with 10M repeat, underrun abort and IPG
module rmii_tx_serializer
  import rmii_pkg::*;
#(
  parameter int DATA_W = DATA_W_RMII,
  parameter int SLOW_DIV = SLOW_DIV_RMII,
  parameter int IPG_BYTES = IPG_BYTES_STD
) (
  input  logic clk,
  input  logic rst,
  input  logic speed_10,
  rmii_tx_serializer_if.slave s,
  output logic [DATA_W-1:0] phy_tx,
  output logic phy_tx_en,
  output logic underrun,
  output logic busy
);
  localparam int SYMS = 8 / DATA_W;
  localparam int CW = $clog2(SYMS);
  state_t state;
  logic [7:0] sr;
  logic [CW-1:0] sym_cnt;
  logic last_q, spd_q, slot_end, ipg_done, eob, acc;
  rmii_slot_timer #(.SLOW_DIV(SLOW_DIV), .IPG_FAST(IPG_BYTES * SYMS)) u_timer (
    .clk, .rst, .spd(spd_q), .run_slot(state == ST_SEND), .run_ipg(state == ST_IPG),
    .slot_end, .ipg_done
  );
  assign eob = state == ST_SEND && sym_cnt == CW'(SYMS - 1) && slot_end;
  assign s.in_ready = !rst && (state == ST_IDLE || (eob && !last_q));
  assign acc = s.in_valid && s.in_ready;
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sr <= '0;
      sym_cnt <= '0;
      last_q <= 1'b0;
      spd_q <= 1'b0;
      phy_tx <= '0;
      phy_tx_en <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= eob && !last_q && !s.in_valid;
      if (acc) begin
        state <= ST_SEND;
        sr <= s.in_data;
        last_q <= s.in_last;
        sym_cnt <= '0;
        phy_tx <= s.in_data[DATA_W-1:0];
        phy_tx_en <= 1'b1;
        if (state == ST_IDLE) spd_q <= speed_10;
      end else if (eob) begin
        // last byte done or upstream starved: either way the line goes quiet on a byte boundary
        state <= ST_IPG;
        phy_tx <= '0;
        phy_tx_en <= 1'b0;
      end else if (state == ST_SEND && slot_end) begin
        sym_cnt <= sym_cnt + 1'b1;
        sr <= sr >> DATA_W;
        phy_tx <= sr[2*DATA_W-1:DATA_W];
      end else if (ipg_done) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rmii_tx_serializer.sv
// tb_rmii_tx_serializer: randomized and directed checks of both bus widths against a per-cycle frame model
module tb_rmii_tx_serializer;
  logic clk = 1'b0, rst = 1'b1, speed_10 = 1'b0;
  always #5 clk = ~clk;
  rmii_tx_serializer_if bs2();
  rmii_tx_serializer_if bs4();
  logic [1:0] tx2;
  logic [3:0] tx4;
  logic en2, en4, ur2, ur4, busy2, busy4;
  rmii_tx_serializer #(.DATA_W(2)) u2 (.clk(clk), .rst(rst), .speed_10(speed_10), .s(bs2),
    .phy_tx(tx2), .phy_tx_en(en2), .underrun(ur2), .busy(busy2));
  rmii_tx_serializer #(.DATA_W(4)) u4 (.clk(clk), .rst(rst), .speed_10(speed_10), .s(bs4),
    .phy_tx(tx4), .phy_tx_en(en4), .underrun(ur4), .busy(busy4));
  int total = 0, bad = 0;
  logic [7:0] fb[8];
  int fn;
  bit f_last;
  logic [7:0] a_obs[1024], e_obs[1024];
  task automatic drive(input bit w4, input bit v, input logic [7:0] d, input bit l);
    if (w4) begin
      bs4.in_valid = v; bs4.in_data = d; bs4.in_last = l;
    end else begin
      bs2.in_valid = v; bs2.in_data = d; bs2.in_last = l;
    end
  endtask
  // observation word per cycle: {en, tx[3:0], ready, underrun, busy}; cycle 0 is the first accept
  task automatic model(input int dw, input int r, output int nc);
    int bt, t;
    bt = (8 / dw) * r;
    for (int i = 0; i < 1024; i++) e_obs[i] = '0;
    e_obs[0][2] = 1'b1;
    t = 1;
    for (int j = 0; j < fn; j++) begin
      for (int k = 0; k < 8 / dw; k++)
        for (int q = 0; q < r; q++) begin
          e_obs[t] = {1'b1, 4'((fb[j] >> (k * dw)) & ((1 << dw) - 1)), 3'b001};
          t++;
        end
      if (j < fn - 1 || !f_last) e_obs[t-1][2] = 1'b1;
    end
    if (!f_last) e_obs[t][1] = 1'b1;
    for (int i = 0; i < 12 * bt; i++) begin
      e_obs[t][0] = 1'b1;
      t++;
    end
    e_obs[t][2] = 1'b1;
    nc = t + 1;
  endtask
  task automatic run_frame(input bit w4, input bit spd, input bit tog, input int nc);
    int idx = 0;
    bit acc;
    speed_10 = spd;
    drive(w4, 1'b1, fb[0], fn == 1 && f_last);
    for (int i = 0; i < nc; i++) begin
      @(negedge clk);
      a_obs[i] = w4 ? {en4, tx4, bs4.in_ready, ur4, busy4} : {en2, 2'b00, tx2, bs2.in_ready, ur2, busy2};
      acc = w4 ? (bs4.in_valid && bs4.in_ready) : (bs2.in_valid && bs2.in_ready);
      @(posedge clk); #1;
      if (tog) speed_10 = ~speed_10;
      if (acc) begin
        idx++;
        if (idx < fn) drive(w4, 1'b1, fb[idx], idx == fn - 1 && f_last);
        else drive(w4, 1'b0, 8'h00, 1'b0);
      end
    end
    speed_10 = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({en2, tx2, bs2.in_ready, ur2, busy2} !== 6'b0) begin
      bad++; $display("FAIL reset_w2 got=%b exp=000000", {en2, tx2, bs2.in_ready, ur2, busy2});
    end
    total++;
    if ({en4, tx4, bs4.in_ready, ur4, busy4} !== 8'b0) begin
      bad++; $display("FAIL reset_w4 got=%b exp=00000000", {en4, tx4, bs4.in_ready, ur4, busy4});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bs2.in_ready, bs4.in_ready, busy2, busy4} !== 4'b1100) begin
      bad++; $display("FAIL reset_release got=%b exp=1100", {bs2.in_ready, bs4.in_ready, busy2, busy4});
    end
    @(posedge clk); #1;
  endtask
  task automatic test_single_100m();
    int nc;
    fb[0] = 8'hD5; fn = 1; f_last = 1'b1;
    model(2, 1, nc);
    run_frame(1'b0, 1'b0, 1'b0, nc);
    for (int i = 0; i < nc; i++) begin
      total++;
      if (a_obs[i] !== e_obs[i]) begin bad++; $display("FAIL single c%0d got=%b exp=%b", i, a_obs[i], e_obs[i]); end
    end
  endtask
  task automatic test_back_to_back();
    int nc;
    fb[0] = 8'h55; fb[1] = 8'hAA; fb[2] = 8'h0F; fn = 3; f_last = 1'b1;
    model(2, 1, nc);
    run_frame(1'b0, 1'b0, 1'b0, nc);
    for (int i = 0; i < nc; i++) begin
      total++;
      if (a_obs[i] !== e_obs[i]) begin bad++; $display("FAIL b2b c%0d got=%b exp=%b", i, a_obs[i], e_obs[i]); end
    end
  endtask
  task automatic test_slow_10m();
    int nc;
    fb[0] = 8'h1B; fn = 1; f_last = 1'b1;
    model(2, 10, nc);
    run_frame(1'b0, 1'b1, 1'b1, nc);
    for (int i = 0; i < nc; i++) begin
      total++;
      if (a_obs[i] !== e_obs[i]) begin bad++; $display("FAIL slow c%0d got=%b exp=%b", i, a_obs[i], e_obs[i]); end
    end
  endtask
  task automatic test_underrun();
    int nc;
    fb[0] = 8'h3C; fb[1] = 8'h99; fn = 1; f_last = 1'b0;
    model(2, 1, nc);
    run_frame(1'b0, 1'b0, 1'b0, nc);
    for (int i = 0; i < nc; i++) begin
      total++;
      if (a_obs[i] !== e_obs[i]) begin bad++; $display("FAIL underrun c%0d got=%b exp=%b", i, a_obs[i], e_obs[i]); end
    end
    fb[0] = 8'hC6; fb[1] = 8'h71; fn = 2; f_last = 1'b1;
    model(2, 1, nc);
    run_frame(1'b0, 1'b0, 1'b0, nc);
    for (int i = 0; i < nc; i++) begin
      total++;
      if (a_obs[i] !== e_obs[i]) begin bad++; $display("FAIL after_underrun c%0d got=%b exp=%b", i, a_obs[i], e_obs[i]); end
    end
  endtask
  task automatic test_nibble();
    int nc;
    fb[0] = 8'hA5; fn = 1; f_last = 1'b1;
    model(4, 1, nc);
    run_frame(1'b1, 1'b0, 1'b0, nc);
    for (int i = 0; i < nc; i++) begin
      total++;
      if (a_obs[i] !== e_obs[i]) begin bad++; $display("FAIL nibble c%0d got=%b exp=%b", i, a_obs[i], e_obs[i]); end
    end
  endtask
  task automatic test_random();
    int nc;
    bit w4, spd, tog;
    for (int n = 0; n < 6; n++) begin
      w4 = 1'($urandom_range(0, 1));
      spd = ($urandom_range(0, 3) == 0);
      tog = 1'($urandom_range(0, 1));
      fn = $urandom_range(1, 4);
      f_last = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 8; j++) fb[j] = 8'($urandom);
      model(w4 ? 4 : 2, spd ? 10 : 1, nc);
      run_frame(w4, spd, tog, nc);
      for (int i = 0; i < nc; i++) begin
        total++;
        if (a_obs[i] !== e_obs[i]) begin
          bad++; $display("FAIL random%0d c%0d got=%b exp=%b", n, i, a_obs[i], e_obs[i]);
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    speed_10 = 1'b0;
    drive(1'b0, 1'b1, 8'hE4, 1'b1);
    @(negedge clk);
    total++;
    if (bs2.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%b exp=1", bs2.in_ready); end
    @(posedge clk); #1 drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({en2, tx2} !== 3'b101) begin bad++; $display("FAIL rmid_sym1 got=%b exp=101", {en2, tx2}); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({en2, tx2} !== 3'b110) begin bad++; $display("FAIL rmid_sym2 got=%b exp=110", {en2, tx2}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({en2, tx2, ur2, busy2} !== 5'b0) begin bad++; $display("FAIL rmid_cleared got=%b exp=00000", {en2, tx2, ur2, busy2}); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({en2, tx2, bs2.in_ready, ur2, busy2} !== 6'b000100) begin
        bad++; $display("FAIL rmid_after c%0d got=%b exp=000100", i, {en2, tx2, bs2.in_ready, ur2, busy2});
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    test_reset();
    test_single_100m();
    test_back_to_back();
    test_slow_10m();
    test_underrun();
    test_nibble();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
